// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // Radix-2 steps per operation
    localparam int MD_ITER = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Trial subtract; diff[WIDTH] is the borrow because rem < divisor on entry
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit returning {hi, lo}.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational
// multiplier (IDLE -> DONE); division always stays iterative.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             result_notok,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state, state_nxt;
    md_op_e           op_r;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] p_hi, p_lo;      // product accumulator or {remainder, quotient}
    logic             neg_res;         // operand signs differ
    logic             neg_rem;         // dividend was negative

    logic             signed_in, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic             is_div, last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    // Operand conditioning at issue: MULT/DIV work on magnitudes
    always_comb begin
        signed_in = ~op[0];
        a_neg_in  = signed_in & src_a[WIDTH-1];
        b_neg_in  = signed_in & src_b[WIDTH-1];
        a_mag_in  = a_neg_in ? -src_a : src_a;
        b_mag_in  = b_neg_in ? -src_b : src_b;
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (p_hi),
        .quo      (p_lo),
        .divisor  (b_mag),
        .rem_next (div_rem_n),
        .quo_next (div_quo_n)
    );

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        is_div  = (op_r == MD_DIV) || (op_r == MD_DIVU);
        last    = (cnt == 6'(MD_ITER - 1));
        mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_mag} : '0);
        if (is_div) begin
            step_hi = div_rem_n;
            step_lo = div_quo_n;
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final step; divide-by-zero returns the raw dividend
    always_comb begin
        prod   = {step_hi, step_lo};
        fin_hi = step_hi;
        fin_lo = step_lo;
        if (is_div) begin
            if (b_mag == '0) begin
                fin_lo = '1;
                fin_hi = neg_rem ? -a_mag : a_mag;   // restores original src_a
            end else begin
                fin_lo = neg_res ? -step_lo : step_lo;
                fin_hi = neg_rem ? -step_hi : step_hi;
            end
        end else begin
            if (neg_res) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

    // Single-cycle multiplier on sign- or zero-extended operands
    always_comb begin
        ext_a     = signed_in ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        ext_b     = signed_in ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        fast_prod = ext_a * ext_b;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state and handshake outputs; flush always returns to IDLE
    always_comb begin
        state_nxt    = state;
        result_notok = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                result_notok = start & ~flush;
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op[1] ? ST_BUSY : ST_DONE;
`else
                    state_nxt = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                result_notok = ~flush;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // Datapath: latch operands at issue, iterate in BUSY, publish on the last step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r    <= MD_MULT;
            cnt     <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (!flush) begin
            if (state == ST_IDLE && start) begin
                op_r    <= md_op_e'(op);
                cnt     <= '0;
                a_mag   <= a_mag_in;
                b_mag   <= b_mag_in;
                neg_res <= a_neg_in ^ b_neg_in;
                neg_rem <= a_neg_in;
                p_hi    <= '0;
                p_lo    <= op[1] ? a_mag_in : b_mag_in;
`ifdef MULDIV_FAST_MUL_EN
                if (!op[1]) begin
                    hi <= fast_prod[2*WIDTH-1:WIDTH];
                    lo <= fast_prod[WIDTH-1:0];
                end
`endif
            end else if (state == ST_BUSY) begin
                p_hi <= step_hi;
                p_lo <= step_lo;
                cnt  <= cnt + 6'd1;
                if (last) begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (default build: iterative multiply).
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        flush = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        result_notok, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .flush(flush),
        .src_a(src_a), .src_b(src_b), .result_notok(result_notok),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue at a negedge (cycle 0) and hold start until done; counts stall cycles.
    // Leaves start=1 during the done cycle; caller decides what follows.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output bit seen);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        stalls = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (result_notok) stalls++;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for done op=%0d", o);
        end
    endtask

    vec_t vecs[11];

    initial begin
        int  stalls;
        bit  seen;
        logic [31:0] keep_hi, keep_lo;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{2'b11, 32'd50,       32'd7,        32'd1,        32'd7};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk); #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_notok", {31'b0, result_notok}, 32'h0);

        // Back-to-back directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, stalls, seen);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            chk($sformatf("v%0d_stalls", i), stalls, 32'd33);
        end
        @(negedge clk);
        start = 1'b0;

        // Flush in BUSY cycle 10: no done, hi/lo untouched
        @(negedge clk);
        keep_hi = 32'h0000000F;
        keep_lo = 32'h0FFFFFFF;
        start = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_notok", {31'b0, result_notok}, 32'h0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1 if (done || result_notok) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", {31'b0, seen}, 32'h0);
        chk("flush_keep_hi", hi, keep_hi);
        chk("flush_keep_lo", lo, keep_lo);

        run_op(2'b01, 32'd6, 32'd7, stalls, seen);
        chk("after_flush_lo", lo, 32'd42);
        chk("after_flush_hi", hi, 32'd0);
        chk("after_flush_stalls", stalls, 32'd33);
        @(negedge clk);
        start = 1'b0;

        // Flush together with start: nothing issues
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd3;
        #1 chk("flush_start_notok", {31'b0, result_notok}, 32'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_start_idle_notok", {31'b0, result_notok}, 32'h0);
        chk("flush_start_done", {31'b0, done}, 32'h0);
        chk("flush_start_lo", lo, 32'd42);

        // Reset pulse in BUSY cycle 5
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd9;
        repeat (5) @(negedge clk);
        start = 1'b0; resetn = 1'b0;
        #1 chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_notok", {31'b0, result_notok}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(2'b10, 32'd1000, 32'd9, stalls, seen);
        chk("post_rst_lo", lo, 32'd111);
        chk("post_rst_hi", hi, 32'd1);
        chk("post_rst_stalls", stalls, 32'd33);
        @(negedge clk);
        start = 1'b0;
        #1 chk("post_rst_done_pulse", {31'b0, done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
